tlk2711_rd_cmd_arb: RTL

//  Round-robin arbiter sharing the single DMA read-command channel (cmd req/ack + read stream) among NUM_REQ requesters.

---
 rtl/tlk2711_rd_cmd_arb_if.sv | 50 +++++
 rtl/tlk2711_rd_cmd_arb.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/tlk2711_rd_cmd_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : tlk2711_rd_cmd_arb_if
// Purpose  : Requester-side and DMA-side signals of the read-command arbiter.
// Revision : 1.0
// ============================================================================
interface tlk2711_rd_cmd_arb_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 48,
   parameter int DLEN_WIDTH = 16,
   parameter int DATA_WIDTH = 64,
   parameter int OUTSTD     = 4
);
   localparam int CMD_W = DLEN_WIDTH + ADDR_WIDTH;
   localparam int CNT_W = $clog2(OUTSTD) + 1;

   logic [NUM_REQ-1:0]       i_req_cmd_req;
   logic [NUM_REQ*CMD_W-1:0] i_req_cmd_data;
   logic [NUM_REQ-1:0]       o_req_cmd_ack;
   logic                     o_rd_cmd_req;
   logic [CMD_W-1:0]         o_rd_cmd_data;
   logic                     i_rd_cmd_ack;
   logic                     i_dma_rd_valid;
   logic                     i_dma_rd_last;
   logic [DATA_WIDTH-1:0]    i_dma_rd_data;
   logic                     o_dma_rd_ready;
   logic [NUM_REQ-1:0]       o_req_rd_valid;
   logic [NUM_REQ-1:0]       o_req_rd_last;
   logic [DATA_WIDTH-1:0]    o_req_rd_data;
   logic [NUM_REQ-1:0]       i_req_rd_ready;
   logic [CNT_W-1:0]         o_outstanding;
   logic                     o_busy;

   // Arbiter view
   modport slave (
      input  i_req_cmd_req, i_req_cmd_data, i_rd_cmd_ack,
      input  i_dma_rd_valid, i_dma_rd_last, i_dma_rd_data, i_req_rd_ready,
      output o_req_cmd_ack, o_rd_cmd_req, o_rd_cmd_data, o_dma_rd_ready,
      output o_req_rd_valid, o_req_rd_last, o_req_rd_data, o_outstanding, o_busy
   );

   // Environment view (requesters + DMA)
   modport master (
      output i_req_cmd_req, i_req_cmd_data, i_rd_cmd_ack,
      output i_dma_rd_valid, i_dma_rd_last, i_dma_rd_data, i_req_rd_ready,
      input  o_req_cmd_ack, o_rd_cmd_req, o_rd_cmd_data, o_dma_rd_ready,
      input  o_req_rd_valid, o_req_rd_last, o_req_rd_data, o_outstanding, o_busy
   );
endinterface
`default_nettype wire

// File: rtl/tlk2711_rd_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tlk2711_rd_cmd_arb
// Purpose  : Round-robin share of the DMA read-command channel; returning
//            read bursts are steered to their owner via an in-order route FIFO.
// Revision : 1.0
// ============================================================================
module tlk2711_rd_cmd_arb #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 48,
   parameter int DLEN_WIDTH = 16,
   parameter int DATA_WIDTH = 64,
   parameter int OUTSTD     = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   tlk2711_rd_cmd_arb_if.slave        bus
);
   localparam int CMD_W = DLEN_WIDTH + ADDR_WIDTH;
   localparam int CNT_W = $clog2(OUTSTD) + 1;
   localparam int PTR_W = $clog2(OUTSTD);
   localparam int IDX_W = $clog2(NUM_REQ);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [IDX_W-1:0]   rr_q, rr_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CMD_W-1:0]   cmd_q, cmd_d;
   logic [NUM_REQ-1:0] cmd_ack_q, cmd_ack_d;
   logic [IDX_W-1:0]   fifo_q [OUTSTD];
   logic [PTR_W-1:0]   wptr_q, rptr_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               w_found;
   logic [IDX_W-1:0]   w_pick;
   logic [IDX_W-1:0]   w_cand;
   logic [CMD_W-1:0]   w_cmd;
   logic               w_push;
   logic               w_pop;
   logic               w_empty;
   logic [IDX_W-1:0]   w_head;
   logic               w_ready;
   logic [NUM_REQ-1:0] w_valid;
   logic [NUM_REQ-1:0] w_last;
   logic [DATA_WIDTH-1:0] w_data;

   // Scan from the highest offset down so the lowest offset from rr_q wins.
   always_comb begin
      w_found = 1'b0;
      w_pick  = rr_q;
      w_cand  = rr_q;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_cand = IDX_W'((32'(rr_q) + 32'(k)) % 32'(NUM_REQ));
         if (bus.i_req_cmd_req[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   always_comb begin
      w_cmd = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_pick == IDX_W'(k)) begin
            w_cmd = bus.i_req_cmd_data[k*CMD_W +: CMD_W];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      idx_d     = idx_q;
      cmd_d     = cmd_q;
      cmd_ack_d = '0;
      w_push    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_found && (cnt_q < CNT_W'(OUTSTD))) begin
               idx_d   = w_pick;
               cmd_d   = w_cmd;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bus.i_rd_cmd_ack) begin
               w_push           = 1'b1;
               cmd_ack_d[idx_q] = 1'b1;
               rr_d    = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
               state_d = S_GAP;
            end
         end
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Routing always follows the oldest unfinished command.
   assign w_empty = (cnt_q == '0);
   assign w_head  = fifo_q[rptr_q];
   assign w_ready = !w_empty && bus.i_req_rd_ready[w_head];
   assign w_pop   = bus.i_dma_rd_valid && w_ready && bus.i_dma_rd_last;
   assign w_data  = bus.i_dma_rd_data;

   always_comb begin
      w_valid = '0;
      w_last  = '0;
      if (!w_empty) begin
         w_valid[w_head] = bus.i_dma_rd_valid;
         w_last[w_head]  = bus.i_dma_rd_last;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         fifo_q[wptr_q] <= idx_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         rr_q      <= '0;
         idx_q     <= '0;
         cmd_q     <= '0;
         cmd_ack_q <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         idx_q     <= idx_d;
         cmd_q     <= cmd_d;
         cmd_ack_q <= cmd_ack_d;
         if (w_push) begin
            wptr_q <= wptr_q + PTR_W'(1);
         end
         if (w_pop) begin
            rptr_q <= rptr_q + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign bus.o_req_cmd_ack  = cmd_ack_q;
   assign bus.o_rd_cmd_req   = (state_q == S_ISSUE);
   assign bus.o_rd_cmd_data  = cmd_q;
   assign bus.o_dma_rd_ready = w_ready;
   assign bus.o_req_rd_valid = w_valid;
   assign bus.o_req_rd_last  = w_last;
   assign bus.o_req_rd_data  = w_data;
   assign bus.o_outstanding  = cnt_q;
   assign bus.o_busy         = (state_q != S_IDLE) || !w_empty;

endmodule
`default_nettype wire
